rc4_ksa_engine: RTL and testbench
=================================

// Module: rc4_ksa_engine
// PURPOSE
// Parametrised RC4 key-scheduling engine that drives a single-port S-box RAM.
// Optionally initialises S[i]=i, then performs the KSA shuffle with a key of KEY_BYTES bytes.
// Sits between the RAM-init/start controller and the PRGA/decrypt stage.
// RAM read latency, S-box depth and key length are parameters.
// PARAMETERS
// ADDR_W     8  S-box index/data width; depth = 2**ADDR_W (min 2).
// KEY_BYTES  3  secret key length in bytes (>=1); byte 0 is the MSB byte of key.
// RD_LAT     2  cycles from address_out issue to valid mem_data (>=1).
// PORTS
// clk             in   1               system clock
// master_reset_n  in   1               async active-low reset
// start           in   1               level request; run while high
// do_init         in   1               sampled with start: 1 = run S[i]=i fill first
// key             in   KEY_BYTES*8     secret key; byte k = key[(KEY_BYTES-1-k)*8 +: 8]
// mem_data        in   ADDR_W          RAM q
// address_out     out  ADDR_W          RAM address
// data_out        out  ADDR_W          RAM write data
// write_out       out  1               RAM wren
// busy            out  1               high from first RAM access until DONE
// done            out  1               level, held in DONE while start high
// BEHAVIOUR
// - Reset (async, master_reset_n=0): state IDLE; address_out, data_out, write_out, busy, done = 0; i, j, kidx = 0.
// - All outputs are registered. write_out is high for exactly one cycle per write.
// - IDLE: when start=1, latch do_init and key, clear i/j/kidx, busy<=1, next INIT or RD_SI.
// - INIT: one write per cycle, addr=i, data=i. After i=2**ADDR_W-1, clear i and go to RD_SI (256 cycles at default).
// - RD_SI: addr=i, wren=0, then WAIT_SI for RD_LAT cycles. On the last wait cycle:
//   si<=mem_data; j<=j+mem_data+key_byte[kidx] (mod 2**ADDR_W).
//   Key bytes wider than ADDR_W are truncated to the low ADDR_W bits.
// - RD_SJ: addr=j, then WAIT_SJ for RD_LAT cycles; capture sj on the last wait cycle.
// - WR_I: addr=i, data=sj, wren=1. WR_J: addr=j, data=si, wren=1.
//   Then i<=i+1; kidx<=(kidx==KEY_BYTES-1)?0:kidx+1 (counter, no modulo divider).
// - Iteration length = 2*RD_LAT+4 cycles. After the WR_J of i=2**ADDR_W-1, go to DONE.
// - i==j: both writes hit the same address; the final value is si, which is correct.
// - DONE: done=1, busy=0, wren=0, addr=0. Stay while start=1; go to IDLE when start=0.
// - start falls mid-run (any state except IDLE/DONE): abort to IDLE next cycle, all outputs 0.
//   A partially shuffled RAM is allowed.
// - key/do_init changes during a run are ignored (latched copy used).
// - Total busy cycles = (do_init ? 2**ADDR_W : 0) + 2**ADDR_W*(2*RD_LAT+4). Default: 2304.
// STRUCTURE
// - Package rc4_pkg: ksa_state_e enum (IDLE, INIT, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_I, WR_J, DONE);
//   default constants ADDR_W/KEY_BYTES/RD_LAT; function key_byte(key, kidx).
// - Sub-module rc4_key_sched: latched key register, wrapping kidx counter, key-byte mux output.
// - Wait states share one down-counter loaded with RD_LAT-1.
// TESTING (RAM model with parametrised latency + C-style golden KSA)
// 1. Default params, key=24'h000000, do_init=1.
//    Expect 256 init writes (addr==data), then writes (0,0),(0,0),(1,1),(1,1),(2,3),(3,2),...
//    The final RAM matches the golden model; done rises 2304 cycles after busy rises.
// 2. Default params, key=24'h4B6579 ("Key").
//    Final S-box matches the golden model; done holds until start=0, then done=0 next cycle.
// 3. RD_LAT=3, ADDR_W=4, KEY_BYTES=5, key=40'h0102030405.
//    kidx sequence 0..4,0..; 16+16*10=176 busy cycles; RAM matches model.
// 4. start dropped at cycle 500 of run 2 -> IDLE next cycle, write_out=0, done=0, busy=0.
//    Restarting gives the correct result after a fresh run.
// 5. Assert master_reset_n during WR_J -> all outputs 0 immediately (async), state IDLE;
//    no further writes until start.
// 6. do_init=0, RAM preloaded with all 8'h00, key=24'h000000.
//    Every iteration has i==j or data 0; RAM stays all zero; busy = 2048 cycles.

Source files
------------

// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key-scheduling engine:
//   - default values for the engine parameters (S-box width, key length,
//     RAM read latency)
//   - ksa_state_e, the engine's FSM state type
//   - key_byte(), which selects byte k of a secret key whose byte 0 sits in
//     the most significant byte position
// No ports (package).
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_KEY_BYTES = 3;
  localparam int DEF_RD_LAT    = 2;

  // key_byte() works on a key zero-extended to this width, so keys up to
  // KEY_MAX_BYTES bytes long are supported.
  localparam int KEY_MAX_BYTES = 32;
  localparam int KEY_MAX_W     = KEY_MAX_BYTES * 8;
  localparam int KEY_SEL_W     = $clog2(KEY_MAX_W);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    RD_SI   = 4'd2,
    WAIT_SI = 4'd3,
    RD_SJ   = 4'd4,
    WAIT_SJ = 4'd5,
    WR_I    = 4'd6,
    WR_J    = 4'd7,
    DONE    = 4'd8
  } ksa_state_e;

  // Byte kidx of an nbytes-long key; byte 0 is the most significant byte.
  // The key must be passed zero-extended to KEY_MAX_W bits.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_W-1:0] key,
                                          input logic [7:0]           kidx,
                                          input logic [7:0]           nbytes);
    logic [KEY_SEL_W-1:0] sel;
    sel = KEY_SEL_W'((nbytes - kidx - 8'd1) * 8'd8);
    return key[sel +: 8];
  endfunction

endpackage

// File: rtl/rc4_key_sched.sv
// -----------------------------------------------------------------------------
// rc4_key_sched
// Holds the engine's private copy of the secret key and walks through its
// bytes, one per KSA iteration, wrapping after the last byte.
// Ports:
//   clk       in   clock
//   i_rst_n   in   async active-low reset
//   i_load    in   capture i_key and restart at byte 0
//   i_adv     in   step to the next key byte (wraps to 0 after the last)
//   i_key     in   KEY_BYTES*8  secret key, byte 0 in the MSB byte
//   o_kbyte   out  ADDR_W       current key byte resized to the S-box width
//                               (truncated to the low bits when ADDR_W < 8)
// -----------------------------------------------------------------------------
module rc4_key_sched
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int KEY_BYTES = DEF_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic                   i_adv,
  input  logic [KEY_BYTES*8-1:0] i_key,
  output logic [ADDR_W-1:0]      o_kbyte
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  logic [KEY_BYTES*8-1:0] r_key;
  logic [KIDX_W-1:0]      r_kidx;
  logic [7:0]             w_byte;

  // Key latch and wrapping byte index; a compare-and-clear avoids a modulo.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key  <= '0;
      r_kidx <= '0;
    end else if (i_load) begin
      r_key  <= i_key;
      r_kidx <= '0;
    end else if (i_adv) begin
      r_kidx <= (r_kidx == KIDX_LAST) ? '0 : (r_kidx + KIDX_W'(1));
    end else begin
      r_kidx <= r_kidx;
    end
  end

  assign w_byte  = key_byte(KEY_MAX_W'(r_key), 8'(r_kidx), 8'(KEY_BYTES));
  assign o_kbyte = ADDR_W'(w_byte);

endmodule

// File: rtl/rc4_ksa_engine.sv
// -----------------------------------------------------------------------------
// rc4_ksa_engine
// RC4 key-scheduling engine driving a single-port S-box RAM. On start it
// optionally fills S[i]=i, then runs the KSA shuffle:
//   for i in 0..N-1: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
// Each iteration is RD_SI, WAIT_SI x RD_LAT, RD_SJ, WAIT_SJ x RD_LAT, WR_I,
// WR_J, i.e. 2*RD_LAT+4 cycles. All outputs are registered, so the RAM sees
// each access one cycle after the state that issues it.
// Ports:
//   clk             in   system clock
//   master_reset_n  in   async active-low reset
//   start           in   level request; the run continues while high and
//                        aborts to IDLE if it drops before DONE
//   do_init         in   sampled with start: 1 = fill S[i]=i first
//   key             in   KEY_BYTES*8 secret key, byte 0 in the MSB byte
//   mem_data        in   ADDR_W  RAM read data
//   address_out     out  ADDR_W  RAM address
//   data_out        out  ADDR_W  RAM write data
//   write_out       out  RAM write enable, one cycle per write
//   busy            out  high from the first RAM access until DONE
//   done            out  high in DONE while start stays high
// -----------------------------------------------------------------------------
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int KEY_BYTES = DEF_KEY_BYTES,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                   clk,
  input  logic                   master_reset_n,
  input  logic                   start,
  input  logic                   do_init,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [ADDR_W-1:0]      mem_data,
  output logic [ADDR_W-1:0]      address_out,
  output logic [ADDR_W-1:0]      data_out,
  output logic                   write_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  ksa_state_e        r_state;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] r_si;
  logic [ADDR_W-1:0] r_sj;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_data;
  logic              r_wr;
  logic              r_busy;
  logic              r_done;

  logic              w_key_load;
  logic              w_key_adv;
  logic [ADDR_W-1:0] w_kbyte;

  // The key is captured when a run is accepted and steps once per completed
  // iteration; an abort (start low) must not advance it.
  assign w_key_load = (r_state == IDLE) && start;
  assign w_key_adv  = (r_state == WR_J) && start;

  rc4_key_sched #(
    .ADDR_W    (ADDR_W),
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sched (
    .clk     (clk),
    .i_rst_n (master_reset_n),
    .i_load  (w_key_load),
    .i_adv   (w_key_adv),
    .i_key   (key),
    .o_kbyte (w_kbyte)
  );

  // Main FSM: sequences the S-box fill and the KSA read/read/write/write
  // iterations and owns every registered RAM and status output.
  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!start && (r_state != IDLE) && (r_state != DONE)) begin
      // Abort mid-run; the RAM is left partially shuffled.
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr <= '0;
          r_data <= '0;
          r_wr   <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= do_init ? INIT : RD_SI;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        INIT: begin
          // One identity write per cycle; r_i wraps back to 0 after the last.
          r_addr <= r_i;
          r_data <= r_i;
          r_wr   <= 1'b1;
          r_i    <= r_i + ADDR_W'(1);
          if (r_i == IDX_LAST) begin
            r_state <= RD_SI;
          end
        end
        RD_SI: begin
          r_addr  <= r_i;
          r_data  <= '0;
          r_wr    <= 1'b0;
          r_cnt   <= CNT_LOAD;
          r_state <= WAIT_SI;
        end
        WAIT_SI: begin
          // Address is held stable for the whole read latency.
          if (r_cnt == '0) begin
            r_si    <= mem_data;
            r_j     <= r_j + mem_data + w_kbyte;
            r_state <= RD_SJ;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
          end
        end
        RD_SJ: begin
          r_addr  <= r_j;
          r_cnt   <= CNT_LOAD;
          r_state <= WAIT_SJ;
        end
        WAIT_SJ: begin
          if (r_cnt == '0) begin
            r_sj    <= mem_data;
            r_state <= WR_I;
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
          end
        end
        WR_I: begin
          r_addr  <= r_i;
          r_data  <= r_sj;
          r_wr    <= 1'b1;
          r_state <= WR_J;
        end
        WR_J: begin
          // When i==j this second write lands on the same word and leaves
          // S[i]=si, which is the correct swap result.
          r_addr <= r_j;
          r_data <= r_si;
          r_wr   <= 1'b1;
          r_i    <= r_i + ADDR_W'(1);
          if (r_i == IDX_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RD_SI;
          end
        end
        DONE: begin
          r_addr <= '0;
          r_data <= '0;
          r_wr   <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_done  <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_addr  <= '0;
          r_data  <= '0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign address_out = r_addr;
  assign data_out    = r_data;
  assign write_out   = r_wr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// -----------------------------------------------------------------------------
// tb_rc4_ksa_engine
// Two engines share one clock: dut_a with default parameters (256-entry
// S-box, 3-byte key, read latency 2) and dut_b with a 16-entry S-box,
// 5-byte key and read latency 3. Each has a behavioural RAM whose read data
// is mem[address_out] delayed so that it is valid on the last wait cycle.
// A C-style KSA model produces the expected write stream and final S-box.
// -----------------------------------------------------------------------------
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- instance A: default parameters
  logic        a_rst_n, a_start, a_init;
  logic [23:0] a_key;
  logic [7:0]  a_q, a_addr, a_dout;
  logic        a_we, a_busy, a_done;
  logic [7:0]  mem_a [256];
  logic        mem_a_clr;

  // ---- instance B: ADDR_W=4, KEY_BYTES=5, RD_LAT=3
  logic        b_rst_n, b_start, b_init;
  logic [39:0] b_key;
  logic [3:0]  b_q1, b_q2, b_addr, b_dout;
  logic        b_we, b_busy, b_done;
  logic [3:0]  mem_b [16];

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .RD_LAT(2)) dut_a (
    .clk(clk), .master_reset_n(a_rst_n), .start(a_start), .do_init(a_init),
    .key(a_key), .mem_data(a_q), .address_out(a_addr), .data_out(a_dout),
    .write_out(a_we), .busy(a_busy), .done(a_done));

  rc4_ksa_engine #(.ADDR_W(4), .KEY_BYTES(5), .RD_LAT(3)) dut_b (
    .clk(clk), .master_reset_n(b_rst_n), .start(b_start), .do_init(b_init),
    .key(b_key), .mem_data(b_q2), .address_out(b_addr), .data_out(b_dout),
    .write_out(b_we), .busy(b_busy), .done(b_done));

  // RAM A: one output register -> data valid two cycles after the address.
  always @(posedge clk) begin
    if (mem_a_clr) begin
      for (int k = 0; k < 256; k++) mem_a[k] <= 8'h00;
    end else if (a_we) begin
      mem_a[a_addr] <= a_dout;
    end
    a_q <= mem_a[a_addr];
  end

  // RAM B: two output registers -> data valid three cycles after the address.
  always @(posedge clk) begin
    if (b_we) mem_b[b_addr] <= b_dout;
    b_q1 <= mem_b[b_addr];
    b_q2 <= b_q1;
  end

  int n_chk = 0;
  int n_err = 0;
  int qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
  int m_wa[$], m_wd[$];
  int m_s[256];
  int m_key[8];
  int a_final[256], b_final[16];
  int a_busy_cnt = 0, b_busy_cnt = 0, a_wr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Golden KSA over an n-entry S-box held in m_s; records every RAM write.
  task automatic model_ksa(input int n, input int nk, input bit init);
    int j, si, sj;
    m_wa.delete();
    m_wd.delete();
    if (init) begin
      for (int k = 0; k < n; k++) begin
        m_s[k] = k;
        m_wa.push_back(k);
        m_wd.push_back(k);
      end
    end
    j = 0;
    for (int i = 0; i < n; i++) begin
      si = m_s[i];
      j = (j + si + m_key[i % nk]) % n;
      sj = m_s[j];
      m_s[i] = sj;
      m_s[j] = si;
      m_wa.push_back(i); m_wd.push_back(sj);
      m_wa.push_back(j); m_wd.push_back(si);
    end
  endtask

  task automatic model_a(input logic [23:0] k, input bit init);
    logic [63:0] kv;
    kv = 64'(k);
    for (int b = 0; b < 3; b++) m_key[b] = int'((kv >> ((2 - b) * 8)) & 64'hFF) & 255;
    for (int x = 0; x < 256; x++) m_s[x] = int'(mem_a[x]);
    model_ksa(256, 3, init);
    qa_addr = m_wa;
    qa_data = m_wd;
    for (int x = 0; x < 256; x++) a_final[x] = m_s[x];
    a_key  = k;
    a_init = init;
  endtask

  task automatic model_b(input logic [39:0] k, input bit init);
    logic [63:0] kv;
    kv = 64'(k);
    for (int b = 0; b < 5; b++) m_key[b] = int'((kv >> ((4 - b) * 8)) & 64'hFF) & 15;
    for (int x = 0; x < 16; x++) m_s[x] = int'(mem_b[x]);
    model_ksa(16, 5, init);
    qb_addr = m_wa;
    qb_data = m_wd;
    for (int x = 0; x < 16; x++) b_final[x] = m_s[x];
    b_key  = k;
    b_init = init;
  endtask

  // One clock cycle; at the falling edge every RAM write of both engines is
  // compared with the head of its expected-write queue.
  task automatic cyc();
    int ea, ed;
    @(negedge clk);
    if (a_we === 1'b1) begin
      a_wr_cnt++;
      n_chk++;
      if (qa_addr.size() == 0) begin
        n_err++;
        $display("FAIL a_write_unexpected: got addr=%0d data=%0d, required no write", a_addr, a_dout);
      end else begin
        ea = qa_addr.pop_front();
        ed = qa_data.pop_front();
        if (int'(a_addr) != ea || int'(a_dout) != ed) begin
          n_err++;
          $display("FAIL a_write: got (%0d,%0d), required (%0d,%0d)", a_addr, a_dout, ea, ed);
        end
      end
    end
    if (a_busy === 1'b1) a_busy_cnt++;
    if (b_we === 1'b1) begin
      n_chk++;
      if (qb_addr.size() == 0) begin
        n_err++;
        $display("FAIL b_write_unexpected: got addr=%0d data=%0d, required no write", b_addr, b_dout);
      end else begin
        ea = qb_addr.pop_front();
        ed = qb_data.pop_front();
        if (int'(b_addr) != ea || int'(b_dout) != ed) begin
          n_err++;
          $display("FAIL b_write: got (%0d,%0d), required (%0d,%0d)", b_addr, b_dout, ea, ed);
        end
      end
    end
    if (b_busy === 1'b1) b_busy_cnt++;
  endtask

  // Run engine A to completion (or abort after abort_at busy cycles).
  task automatic exec_a(input int exp_busy, input int abort_at, input string tag);
    int c, bad;
    c = 0;
    a_busy_cnt = 0;
    a_start = 1'b1;
    while (a_done !== 1'b1 && c < 4000) begin
      cyc();
      c++;
      if (abort_at > 0 && a_busy_cnt == abort_at) break;
    end
    if (abort_at > 0) begin
      chk({tag, "_abort_point"}, a_busy_cnt, abort_at);
      a_start = 1'b0;
      cyc();
      chk({tag, "_abort_outputs"}, int'({a_we, a_busy, a_done, a_addr, a_dout}), 0);
      qa_addr.delete();
      qa_data.delete();
      return;
    end
    chk({tag, "_done_seen"}, int'(a_done), 1);
    chk({tag, "_busy_cycles"}, a_busy_cnt, exp_busy);
    chk({tag, "_busy_low_at_done"}, int'(a_busy), 0);
    chk({tag, "_writes_left"}, qa_addr.size(), 0);
    repeat (4) cyc();
    chk({tag, "_done_held"}, int'({a_done, a_busy, a_we}), 4);
    a_start = 1'b0;
    cyc();
    chk({tag, "_done_cleared"}, int'({a_done, a_busy, a_we}), 0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem_a[k]) != a_final[k]) bad++;
    chk({tag, "_final_sbox_mismatches"}, bad, 0);
  endtask

  int p_t1_a[6] = '{0, 0, 1, 1, 2, 3};
  int p_t1_d[6] = '{0, 0, 1, 1, 3, 2};
  int p_t3_a[6] = '{0, 1, 1, 3, 2, 8};
  int p_t3_d[6] = '{1, 0, 3, 0, 8, 2};

  initial begin
    int c, bad, found;
    logic prev_we;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_init = 1'b0;  b_init = 1'b0;
    a_key = 24'h0;  b_key = 40'h0;
    mem_a_clr = 1'b0;
    repeat (3) cyc();
    chk("a_reset_outputs", int'({a_we, a_busy, a_done, a_addr, a_dout}), 0);
    chk("b_reset_outputs", int'({b_we, b_busy, b_done, b_addr, b_dout}), 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    repeat (2) cyc();
    chk("a_idle_outputs", int'({a_we, a_busy, a_done, a_addr, a_dout}), 0);

    // 1: zero key with fill; pin the first shuffle writes of the model
    model_a(24'h000000, 1'b1);
    chk("t1_model_write_count", m_wa.size(), 768);
    for (int k = 0; k < 6; k++) begin
      chk("t1_model_addr", m_wa[256 + k], p_t1_a[k]);
      chk("t1_model_data", m_wd[256 + k], p_t1_d[k]);
    end
    exec_a(2304, 0, "t1");

    // 2: key "Key"
    model_a(24'h4B6579, 1'b1);
    exec_a(2304, 0, "t2");

    // 3: small engine, 5-byte key, key bytes 1..5
    model_b(40'h0102030405, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("t3_model_addr", m_wa[16 + k], p_t3_a[k]);
      chk("t3_model_data", m_wd[16 + k], p_t3_d[k]);
    end
    b_busy_cnt = 0;
    b_start = 1'b1;
    c = 0;
    while (b_done !== 1'b1 && c < 1000) begin cyc(); c++; end
    chk("t3_done_seen", int'(b_done), 1);
    chk("t3_busy_cycles", b_busy_cnt, 176);
    chk("t3_writes_left", qb_addr.size(), 0);
    repeat (3) cyc();
    b_start = 1'b0;
    cyc();
    chk("t3_done_cleared", int'({b_done, b_busy, b_we}), 0);
    bad = 0;
    for (int k = 0; k < 16; k++) if (int'(mem_b[k]) != b_final[k]) bad++;
    chk("t3_final_sbox_mismatches", bad, 0);

    // 4: abort at busy cycle 500, then a fresh full run
    model_a(24'h4B6579, 1'b1);
    exec_a(2304, 500, "t4a");
    repeat (3) cyc();
    model_a(24'h4B6579, 1'b1);
    exec_a(2304, 0, "t4b");

    // 5: async reset while the engine sits in WR_J (first cycle of a write pair)
    model_a(24'h000000, 1'b1);
    a_busy_cnt = 0;
    a_start = 1'b1;
    c = 0; found = 0; prev_we = 1'b0;
    while (found == 0 && c < 3000) begin
      cyc();
      c++;
      if (a_busy_cnt > 300 && a_we === 1'b1 && prev_we === 1'b0) found = 1;
      prev_we = a_we;
    end
    chk("t5_wr_j_reached", found, 1);
    a_rst_n = 1'b0;
    a_start = 1'b0;
    #1;
    chk("t5_reset_async_outputs", int'({a_we, a_busy, a_done, a_addr, a_dout}), 0);
    qa_addr.delete();
    qa_data.delete();
    repeat (2) cyc();
    a_rst_n = 1'b1;
    a_wr_cnt = 0;
    repeat (20) cyc();
    chk("t5_no_writes_after_reset", a_wr_cnt, 0);
    chk("t5_idle_after_reset", int'({a_busy, a_done}), 0);

    // 6: no fill, RAM all zero, zero key -> everything stays zero
    mem_a_clr = 1'b1;
    cyc();
    mem_a_clr = 1'b0;
    model_a(24'h000000, 1'b0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (a_final[k] != 0) bad++;
    for (int k = 0; k < m_wd.size(); k++) if (m_wd[k] != 0) bad++;
    chk("t6_model_all_zero", bad, 0);
    exec_a(2048, 0, "t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
